mul_div_unit: RTL and testbench
===============================

# mul_div_unit

Iterative multiply/divide unit for the single-issue datapath. It sits directly downstream of the register file's two read ports and takes Rdata1/Rdata2 as its operands. MULT/MULTU/DIV/DIVU execute over a fixed latency into the architectural HI/LO registers, which the writeback mux reads for MFHI/MFLO. The controller stalls issue while `busy` is high.

## Interface
- `WIDTH`, 32, operand and HI/LO width. All test values assume 32.
- `clk`  in  1  rising-edge clock
- `rst`  in  1  reset, asynchronous, active-high
- `start`  in  1  request; sampled only in IDLE
- `op`  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU; captured with start
- `a`  in  WIDTH  operand rs (register-file Rdata1); captured with start
- `b`  in  WIDTH  operand rt (register-file Rdata2); captured with start
- `busy`  out  1  high whenever state != IDLE
- `done`  out  1  one-cycle pulse when HI/LO are updated
- `hi`  out  WIDTH  HI register: product upper half, or remainder
- `lo`  out  WIDTH  LO register: product lower half, or quotient

## Operation
- States:
  - IDLE: `start` latches `op`, `a`, `b` into internal registers and moves to RUN with count=0.
  - RUN: performs exactly WIDTH iterations, one per cycle, then moves to FIX.
  - FIX: applies sign correction, writes `hi`/`lo`, sets `done`=1, then returns to IDLE.
- Signed ops (MULT, DIV) iterate on absolute values.
  - MULT: the 2·WIDTH product is negated if sign(a)^sign(b).
  - DIV: the quotient is negated if sign(a)^sign(b). The remainder takes sign(a).
- Multiply: shift-add on a 2·WIDTH accumulator. Divide: restoring division, one quotient bit per cycle.
- Divide by zero: latency is unchanged. `lo` = all ones and `hi` = a (the original signed/unsigned dividend). No trap.
- DIV 0x80000000 / 0xFFFFFFFF: `lo` = 0x80000000, `hi` = 0. The quotient wraps; no overflow flag.
- `start` while busy (RUN or FIX) is ignored. The request is not queued.
- Changes to `a`, `b`, `op` after capture have no effect on the operation in flight.
- `hi`/`lo` hold their value between operations and change only at FIX.

## Timing
- Reset values:
  - state = IDLE.
  - `busy`, `done` = 0.
  - `hi`, `lo` = 0.
  - internal accumulators and counter = 0.
- `rst` mid-operation aborts immediately and applies the reset values. No partial result is written.
- `start` sampled high at edge N:
  - `busy` rises after edge N.
  - Iterations run on edges N+1..N+WIDTH.
  - FIX runs on edge N+WIDTH+1, which writes `hi`/`lo`, sets `done`=1 and sets `busy`=0.
  - `done` falls at edge N+WIDTH+2.
- Total latency is 33 cycles (start edge to result) for every op and every operand value.
- Back-to-back: the earliest next `start` is sampled at edge N+WIDTH+2, in the same cycle `done` is high. That start is accepted.
- `busy` is decoded from the state register. `done` is a registered output.

## Structure
- Package `mdu_pkg` holds:
  - op encodings `MDU_MULT`, `MDU_MULTU`, `MDU_DIV`, `MDU_DIVU`
  - state enum (IDLE, RUN, FIX)
  - default `WIDTH`, matching the register-file data width
- Single module, with no sub-module. The FSM, counter (log2(WIDTH)+1 bits) and shared 2·WIDTH shift register are tightly coupled. Expected size is about 200 lines.

## Test plan
- MULTU 0xFFFFFFFF × 0xFFFFFFFF, start at edge N -> `hi`=0xFFFFFFFE, `lo`=0x00000001, `done`=1 exactly in the cycle after edge N+33, `busy` low from then.
- MULT -3 × 7 -> `hi`=0xFFFFFFFF, `lo`=0xFFFFFFEB.
- DIV -7 / 2 -> `lo`=0xFFFFFFFD, `hi`=0xFFFFFFFF.
- DIVU 100 / 7 -> `lo`=14, `hi`=2.
- DIVU 5 / 0 -> `lo`=0xFFFFFFFF, `hi`=5.
- DIV 0x80000000 / 0xFFFFFFFF -> `lo`=0x80000000, `hi`=0.
- Both divide-edge cases above complete with latency 33.
- Busy-window start: start MULTU 3×4, pulse `start` with op DIVU 9/3 at iteration 5, and change `a`/`b` mid-run -> result `hi`=0, `lo`=12. Only one `done` pulse occurs.
- Reset mid-op: `rst` at iteration 10 of MULT 2×2 with `hi`/`lo` previously 0xAAAA… -> `hi`/`lo`/`busy`/`done` are 0 immediately. After release, a new MULTU 6×7 yields `lo`=42 at full latency.

Source files
------------

// File: rtl/mul_div_unit_pkg.sv
// Shared definitions for the iterative multiply/divide unit.
//   MDU_WIDTH   : default operand / HI / LO width (register-file data width)
//   mdu_op_e    : operation encodings as driven on the 2-bit op bus
//   mdu_state_e : sequencer states
package mdu_pkg;

  localparam int unsigned MDU_WIDTH = 32;

  typedef enum logic [1:0] {
    MDU_MULT  = 2'b00,
    MDU_MULTU = 2'b01,
    MDU_DIV   = 2'b10,
    MDU_DIVU  = 2'b11
  } mdu_op_e;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FIX
  } mdu_state_e;

endpackage

// File: rtl/mul_div_unit_if.sv
// Request/result bundle between the issue stage and the multiply/divide unit.
//   start, op, a, b : request, driven by the issue stage (master)
//   busy, done      : status, driven by the unit (slave)
//   hi, lo          : architectural HI/LO registers, driven by the unit
interface mul_div_unit_if
  import mdu_pkg::*;
#(
  parameter int unsigned WIDTH = MDU_WIDTH
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, a, b,
    input  busy, done, hi, lo
  );

  modport slave (
    input  start, op, a, b,
    output busy, done, hi, lo
  );
endinterface

// File: rtl/mul_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit writing the HI/LO registers.
//   clk : rising-edge clock
//   rst : asynchronous, active-high reset
//   bus : slave side of mul_div_unit_if
//         start/op/a/b captured in IDLE; busy = state != IDLE;
//         done pulses one cycle when hi/lo are written (33 cycles after start).
// Signed ops iterate on magnitudes; signs are restored in FIX.
module mul_div_unit
  import mdu_pkg::*;
#(
  parameter int unsigned WIDTH = MDU_WIDTH
) (
  input  logic          clk,
  input  logic          rst,
  mul_div_unit_if.slave bus
);

  localparam int unsigned CNT_W = $clog2(WIDTH) + 1;

  mdu_state_e         state_q;
  mdu_op_e            op_q;
  logic [WIDTH-1:0]   a_q;
  logic [WIDTH-1:0]   bmag_q;
  logic               sgn_a_q;
  logic               sgn_b_q;
  logic [2*WIDTH-1:0] acc_q;
  logic [2*WIDTH-1:0] acc_d;
  logic [CNT_W-1:0]   cnt_q;
  logic               done_q;
  logic [WIDTH-1:0]   hi_q;
  logic [WIDTH-1:0]   lo_q;

  // Request decode (used only when capturing in IDLE)
  logic             req_signed;
  logic             req_sgn_a;
  logic             req_sgn_b;
  logic [WIDTH-1:0] req_amag;
  logic [WIDTH-1:0] req_bmag;

  // Iteration datapath
  logic             is_div;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   sh_hi;
  logic [WIDTH+1:0] diff;

  // Sign-correction datapath
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   res_hi;
  logic [WIDTH-1:0]   res_lo;

  always_comb begin
    req_signed = ~bus.op[0];
    req_sgn_a  = req_signed & bus.a[WIDTH-1];
    req_sgn_b  = req_signed & bus.b[WIDTH-1];
    req_amag   = req_sgn_a ? -bus.a : bus.a;
    req_bmag   = req_sgn_b ? -bus.b : bus.b;
  end

  // acc_q holds {partial product, multiplier} for multiply and
  // {partial remainder, dividend/quotient} for divide; both shift one bit per cycle.
  always_comb begin
    is_div  = (op_q == MDU_DIV) || (op_q == MDU_DIVU);
    mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, bmag_q} : '0);
    sh_hi   = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    diff    = {1'b0, sh_hi} - {2'b00, bmag_q};
    acc_d   = acc_q;
    if (is_div) begin
      // Restoring step: the partial remainder is always below the divisor,
      // so the restored value fits back into WIDTH bits.
      if (!diff[WIDTH+1]) begin
        acc_d = {diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
      end else begin
        acc_d = {sh_hi[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
      end
    end else begin
      acc_d = {mul_sum, acc_q[WIDTH-1:1]};
    end
  end

  always_comb begin
    prod   = acc_q;
    res_hi = acc_q[2*WIDTH-1:WIDTH];
    res_lo = acc_q[WIDTH-1:0];
    if (!is_div) begin
      if (sgn_a_q ^ sgn_b_q) begin
        prod   = -acc_q;
        res_hi = prod[2*WIDTH-1:WIDTH];
        res_lo = prod[WIDTH-1:0];
      end
    end else if (bmag_q == '0) begin
      // Divide by zero: fixed result independent of sign handling.
      res_lo = '1;
      res_hi = a_q;
    end else begin
      if (sgn_a_q ^ sgn_b_q) res_lo = -acc_q[WIDTH-1:0];
      if (sgn_a_q)           res_hi = -acc_q[2*WIDTH-1:WIDTH];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      op_q    <= MDU_MULT;
      a_q     <= '0;
      bmag_q  <= '0;
      sgn_a_q <= 1'b0;
      sgn_b_q <= 1'b0;
      acc_q   <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (bus.start) begin
            op_q    <= mdu_op_e'(bus.op);
            a_q     <= bus.a;
            bmag_q  <= req_bmag;
            sgn_a_q <= req_sgn_a;
            sgn_b_q <= req_sgn_b;
            acc_q   <= {{WIDTH{1'b0}}, req_amag};
            cnt_q   <= '0;
            state_q <= RUN;
          end
        end
        RUN: begin
          acc_q <= acc_d;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CNT_W'(WIDTH - 1)) state_q <= FIX;
        end
        FIX: begin
          hi_q    <= res_hi;
          lo_q    <= res_lo;
          done_q  <= 1'b1;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.busy = (state_q != IDLE);
  assign bus.done = done_q;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;

endmodule

// File: tb/tb_mul_div_unit.sv
module tb_mul_div_unit;
  import mdu_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   passes = 0;

  mul_div_unit_if #(.WIDTH(32)) bus ();

  mul_div_unit #(.WIDTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Reference: plain 64-bit arithmetic on the architectural definitions.
  function automatic void model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                                output logic [31:0] eh, output logic [31:0] el);
    longint      sx, sy, q, r;
    logic [63:0] p;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    eh = '0;
    el = '0;
    case (o)
      2'b00: begin p = 64'(sx * sy); eh = p[63:32]; el = p[31:0]; end
      2'b01: begin p = {32'd0, x} * {32'd0, y}; eh = p[63:32]; el = p[31:0]; end
      2'b10: begin
        if (y == 0) begin el = 32'hFFFF_FFFF; eh = x; end
        else begin
          q = sx / sy; r = sx % sy;
          p = 64'(q); el = p[31:0];
          p = 64'(r); eh = p[31:0];
        end
      end
      default: begin
        if (y == 0) begin el = 32'hFFFF_FFFF; eh = x; end
        else begin el = x / y; eh = x % y; end
      end
    endcase
  endfunction

  // Drives one request, scrambles inputs after capture, measures latency to done.
  task automatic run_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                        output int lat, output logic busy_s, output logic done_s,
                        output logic busy_d);
    @(negedge clk);
    bus.start = 1'b1; bus.op = o; bus.a = x; bus.b = y;
    @(posedge clk); #1;
    busy_s = bus.busy;
    done_s = bus.done;
    bus.start = 1'b0;
    bus.a = $urandom; bus.b = $urandom; bus.op = 2'($urandom);
    lat = 0;
    while (bus.done !== 1'b1 && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    busy_d = bus.busy;
  endtask

  task automatic test_reset;
    bus.start = 1'b0; bus.op = 2'b00; bus.a = '0; bus.b = '0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({bus.busy, bus.done, bus.hi, bus.lo} !== 66'd0)
      $display("FAIL reset_state busy=%b done=%b hi=%h lo=%h expected all zero",
               bus.busy, bus.done, bus.hi, bus.lo);
    else passes++;
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_directed;
    logic [1:0]  ops [7] = '{2'b01, 2'b00, 2'b10, 2'b11, 2'b11, 2'b10, 2'b10};
    logic [31:0] as  [7] = '{32'hFFFF_FFFF, 32'hFFFF_FFFD, 32'hFFFF_FFF9, 32'd100, 32'd5,
                             32'h8000_0000, 32'hFFFF_FFF9};
    logic [31:0] bs  [7] = '{32'hFFFF_FFFF, 32'd7, 32'd2, 32'd7, 32'd0, 32'hFFFF_FFFF, 32'd0};
    logic [31:0] xh  [7] = '{32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd2, 32'd5, 32'd0,
                             32'hFFFF_FFF9};
    logic [31:0] xl  [7] = '{32'h0000_0001, 32'hFFFF_FFEB, 32'hFFFF_FFFD, 32'd14, 32'hFFFF_FFFF,
                             32'h8000_0000, 32'hFFFF_FFFF};
    int lat; logic bs_, ds_, bd_;
    for (int i = 0; i < 7; i++) begin
      run_op(ops[i], as[i], bs[i], lat, bs_, ds_, bd_);
      checks++;
      if (lat != 33) $display("FAIL dir%0d_latency got=%0d exp=33", i, lat); else passes++;
      checks++;
      if (bus.hi !== xh[i] || bus.lo !== xl[i])
        $display("FAIL dir%0d_result hi=%h lo=%h exp hi=%h lo=%h", i, bus.hi, bus.lo, xh[i], xl[i]);
      else passes++;
      checks++;
      if (bs_ !== 1'b1 || bd_ !== 1'b0)
        $display("FAIL dir%0d_busy after_start=%b at_done=%b exp 1/0", i, bs_, bd_);
      else passes++;
    end
  endtask

  task automatic test_random;
    int lat; logic bs_, ds_, bd_;
    logic [1:0] o; logic [31:0] x, y, eh, el;
    for (int i = 0; i < 24; i++) begin
      o = 2'($urandom);
      x = $urandom;
      case ($urandom_range(0, 3))
        0: y = 32'($urandom_range(0, 9));
        1: y = -32'($urandom_range(1, 9));
        default: y = $urandom;
      endcase
      model(o, x, y, eh, el);
      run_op(o, x, y, lat, bs_, ds_, bd_);
      checks++;
      if (lat != 33 || bus.hi !== eh || bus.lo !== el)
        $display("FAIL rand%0d op=%0d a=%h b=%h got lat=%0d hi=%h lo=%h exp lat=33 hi=%h lo=%h",
                 i, o, x, y, lat, bus.hi, bus.lo, eh, el);
      else passes++;
    end
  endtask

  task automatic test_back_to_back;
    int lat; logic bs_, ds_, bd_;
    logic [31:0] eh, el;
    run_op(2'b01, 32'd1234, 32'd5678, lat, bs_, ds_, bd_);
    // Second request is issued in the cycle done is high.
    run_op(2'b11, 32'd1000, 32'd33, lat, bs_, ds_, bd_);
    checks++;
    if (bs_ !== 1'b1 || ds_ !== 1'b0)
      $display("FAIL b2b_accept busy=%b done=%b exp busy=1 done=0", bs_, ds_);
    else passes++;
    model(2'b11, 32'd1000, 32'd33, eh, el);
    checks++;
    if (lat != 33 || bus.hi !== eh || bus.lo !== el)
      $display("FAIL b2b_result lat=%0d hi=%h lo=%h exp lat=33 hi=%h lo=%h", lat, bus.hi, bus.lo, eh, el);
    else passes++;
  endtask

  task automatic test_busy_start;
    int pulses = 0;
    logic [31:0] eh, el;
    @(negedge clk);
    bus.start = 1'b1; bus.op = 2'b01; bus.a = 32'd3; bus.b = 32'd4;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    bus.start = 1'b1; bus.op = 2'b11; bus.a = 32'd9; bus.b = 32'd3;
    @(posedge clk); #1;
    bus.start = 1'b0; bus.a = 32'd77; bus.b = 32'd55;
    for (int i = 0; i < 45; i++) begin
      @(posedge clk); #1;
      if (bus.done === 1'b1) pulses++;
    end
    model(2'b01, 32'd3, 32'd4, eh, el);
    checks++;
    if (bus.hi !== eh || bus.lo !== el)
      $display("FAIL busy_start_result hi=%h lo=%h exp hi=%h lo=%h", bus.hi, bus.lo, eh, el);
    else passes++;
    checks++;
    if (pulses != 1) $display("FAIL busy_start_pulses got=%0d exp=1", pulses); else passes++;
  endtask

  task automatic test_reset_mid;
    int lat; logic bs_, ds_, bd_;
    logic [31:0] eh, el;
    // Preload HI/LO with 0xAAAAAAAA_AAAAAAAA.
    run_op(2'b01, 32'd3444014338, 32'd3570783445, lat, bs_, ds_, bd_);
    checks++;
    if (bus.hi !== 32'hAAAA_AAAA || bus.lo !== 32'hAAAA_AAAA)
      $display("FAIL preload hi=%h lo=%h exp aaaaaaaa/aaaaaaaa", bus.hi, bus.lo);
    else passes++;
    @(negedge clk);
    bus.start = 1'b1; bus.op = 2'b00; bus.a = 32'd2; bus.b = 32'd2;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if ({bus.busy, bus.done, bus.hi, bus.lo} !== 66'd0)
      $display("FAIL reset_mid busy=%b done=%b hi=%h lo=%h exp all zero",
               bus.busy, bus.done, bus.hi, bus.lo);
    else passes++;
    @(negedge clk); rst = 1'b0;
    run_op(2'b01, 32'd6, 32'd7, lat, bs_, ds_, bd_);
    model(2'b01, 32'd6, 32'd7, eh, el);
    checks++;
    if (lat != 33 || bus.lo !== el || bus.hi !== eh)
      $display("FAIL after_reset lat=%0d hi=%h lo=%h exp lat=33 hi=%h lo=%h", lat, bus.hi, bus.lo, eh, el);
    else passes++;
  endtask

  initial begin
    test_reset;
    test_directed;
    test_back_to_back;
    test_busy_start;
    test_reset_mid;
    test_random;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
